freq_measure_ctrl: RTL

Sequencing controller for the auto-scaled low-frequency counter. On a start request it runs the period counter, then the divider to convert period to frequency, then the binary-to-BCD converter, and finally normalizes the BCD result to four significant digits plus a decimal exponent for the display. It owns every start pulse in the datapath and is the only block the top level talks to for a measurement.

---
 rtl/freq_measure_if.sv | 38 +++
 rtl/freq_measure_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/freq_measure_if.sv
// Handshake bundle between the measurement sequencer and the top level / datapath.
// The slave modport is the controller's view; master is the driving side.
interface freq_measure_if #(
  parameter int PERIOD_W = 16
);
  logic                start_i;
  logic                period_start_o;
  logic                period_done_i;
  logic [PERIOD_W-1:0] period_count_i;
  logic                div_start_o;
  logic [19:0]         div_dividend_o;
  logic [PERIOD_W-1:0] div_divisor_o;
  logic                div_done_i;
  logic [19:0]         div_quotient_i;
  logic                bcd_start_o;
  logic [19:0]         bcd_bin_o;
  logic                bcd_done_i;
  logic [27:0]         bcd_digits_i;
  logic                busy_o;
  logic                done_o;
  logic [15:0]         digits_o;
  logic [1:0]          exp_o;
  logic [1:0]          err_o;

  modport slave (
    input  start_i, period_done_i, period_count_i, div_done_i, div_quotient_i,
           bcd_done_i, bcd_digits_i,
    output period_start_o, div_start_o, div_dividend_o, div_divisor_o,
           bcd_start_o, bcd_bin_o, busy_o, done_o, digits_o, exp_o, err_o
  );

  modport master (
    output start_i, period_done_i, period_count_i, div_done_i, div_quotient_i,
           bcd_done_i, bcd_digits_i,
    input  period_start_o, div_start_o, div_dividend_o, div_divisor_o,
           bcd_start_o, bcd_bin_o, busy_o, done_o, digits_o, exp_o, err_o
  );
endinterface

// File: rtl/freq_measure_ctrl.sv
// Sequencer for the auto-scaled frequency counter: period -> divide -> BCD -> normalise.
// Optional MEASURE watchdog enabled by defining FREQ_CTRL_TIMEOUT_EN.
module freq_measure_ctrl #(
  parameter int PERIOD_W       = 16,
  parameter int DIVIDEND       = 1_000_000,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input logic          clk_i,
  input logic          reset_i,
  freq_measure_if.slave bus
);

  localparam logic [19:0] DIVIDEND_C = 20'(DIVIDEND);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MEASURE = 3'd1,
    DIV     = 3'd2,
    BCD     = 3'd3,
    NORM    = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t              state_r;
  logic [27:0]         sr_r;
  logic [1:0]          shift_cnt_r;
  logic                period_start_r;
  logic                div_start_r;
  logic                bcd_start_r;
  logic [PERIOD_W-1:0] divisor_r;
  logic [19:0]         bin_r;
  logic                busy_r;
  logic                done_r;
  logic [15:0]         digits_r;
  logic [1:0]          exp_r;
  logic [1:0]          err_r;
  logic                tmo_hit_s;

`ifdef FREQ_CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_r;

  assign tmo_hit_s = (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts MEASURE cycles, held at zero everywhere else.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (state_r == MEASURE) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end else begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Measurement sequencer; start pulses are raised on the transition into each stage.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r        <= IDLE;
      sr_r           <= 28'd0;
      shift_cnt_r    <= 2'd0;
      period_start_r <= 1'b0;
      div_start_r    <= 1'b0;
      bcd_start_r    <= 1'b0;
      divisor_r      <= {PERIOD_W{1'b0}};
      bin_r          <= 20'd0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      digits_r       <= 16'd0;
      exp_r          <= 2'd0;
      err_r          <= 2'd0;
    end else begin
      period_start_r <= 1'b0;
      div_start_r    <= 1'b0;
      bcd_start_r    <= 1'b0;
      done_r         <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start_i) begin
            state_r        <= MEASURE;
            period_start_r <= 1'b1;
            busy_r         <= 1'b1;
            err_r          <= 2'd0;
          end else begin
            busy_r <= 1'b0;
          end
        end
        MEASURE: begin
          if (bus.period_done_i) begin
            divisor_r <= bus.period_count_i;
            if (bus.period_count_i == {PERIOD_W{1'b0}}) begin
              err_r   <= 2'd1;
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              div_start_r <= 1'b1;
              state_r     <= DIV;
            end
          end else if (tmo_hit_s) begin
            err_r   <= 2'd2;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            state_r <= MEASURE;
          end
        end
        DIV: begin
          if (bus.div_done_i) begin
            bin_r       <= bus.div_quotient_i;
            bcd_start_r <= 1'b1;
            state_r     <= BCD;
          end else begin
            state_r <= DIV;
          end
        end
        BCD: begin
          if (bus.bcd_done_i) begin
            sr_r        <= bus.bcd_digits_i;
            shift_cnt_r <= 2'd0;
            state_r     <= NORM;
          end else begin
            state_r <= BCD;
          end
        end
        NORM: begin
          // Strip leading zero digits, but never below a 10^0 exponent.
          if ((sr_r[27:24] == 4'd0) && (shift_cnt_r < 2'd3)) begin
            sr_r        <= {sr_r[23:0], 4'd0};
            shift_cnt_r <= shift_cnt_r + 2'd1;
          end else begin
            digits_r <= sr_r[27:12];
            exp_r    <= 2'd3 - shift_cnt_r;
            err_r    <= 2'd0;
            done_r   <= 1'b1;
            state_r  <= DONE;
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.period_start_o = period_start_r;
  assign bus.div_start_o    = div_start_r;
  assign bus.div_dividend_o = DIVIDEND_C;
  assign bus.div_divisor_o  = divisor_r;
  assign bus.bcd_start_o    = bcd_start_r;
  assign bus.bcd_bin_o      = bin_r;
  assign bus.busy_o         = busy_r;
  assign bus.done_o         = done_r;
  assign bus.digits_o       = digits_r;
  assign bus.exp_o          = exp_r;
  assign bus.err_o          = err_r;

endmodule
